// File: rtl/seqmult_sched_sf_48_pkg.sv
// rtl/seqmult_sched_sf_48_pkg.sv - shared constants and FSM encoding for the 48 kHz L+R/L-R gain scheduler.
package seqmult_sched_sf_48_pkg;

  localparam int DEF_N     = 18;
  localparam int DEF_M     = 5;
  localparam int MIX_SHIFT = 3;
  localparam int OUT_SHIFT = 5;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START_S = 3'd1,
    ST_BUSY_S  = 3'd2,
    ST_DONE_S  = 3'd3,
    ST_START_D = 3'd4,
    ST_BUSY_D  = 3'd5,
    ST_DONE_D  = 3'd6,
    ST_UPDATE  = 3'd7
  } sched_state_e;

endpackage

// File: rtl/seqmult_sched_sf_48_if.sv
// rtl/seqmult_sched_sf_48_if.sv - start/ready handshake to the shared sequential multiplier.
interface seqmult_sched_sf_48_if
  import seqmult_sched_sf_48_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int M = DEF_M
);
  logic                    mult_start;
  logic signed [N-1:0]     mult_A;
  logic signed [M-1:0]     mult_B;
  logic                    mult_ready;
  logic signed [N+M-1:0]   mult_R;

  modport master (output mult_start, mult_A, mult_B, input mult_ready, mult_R);
  modport slave  (input mult_start, mult_A, mult_B, output mult_ready, mult_R);
endinterface

// File: rtl/seqmultNM.sv
// rtl/seqmultNM.sv - M-cycle shift/add signed multiplier (N x M -> N+M) with start/ready handshake.
module seqmultNM #(
  parameter int N = 18,
  parameter int M = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic signed [N-1:0]   A,
  input  logic signed [M-1:0]   B,
  output logic                  ready,
  output logic signed [N+M-1:0] R
);
  localparam int CW = $clog2(M + 1);

  logic signed [N+M-1:0] acc_q, acc_d, a_q, a_d, pp;
  logic [M-1:0]          b_q, b_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  ready_q, ready_d;

  always_comb begin
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    pp      = b_q[0] ? a_q : '0;
    if (ready_q) begin
      if (start) begin
        a_d     = {{M{A[N-1]}}, A};
        b_d     = B;
        acc_d   = '0;
        cnt_d   = CW'(M);
        ready_d = 1'b0;
      end
    end else begin
      // Last step handles B's sign bit, which carries negative weight.
      acc_d = (cnt_q == CW'(1)) ? acc_q - pp : acc_q + pp;
      a_d   = a_q << 1;
      b_d   = b_q >> 1;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) ready_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  assign ready = ready_q;
  assign R     = acc_q;
endmodule

// File: rtl/seqmult_sched_sf_48_mix.sv
// rtl/seqmult_sched_sf_48_mix.sv - sf48_mix: registered (L+R)<<3 and (L-R)<<3, wrapping in N bits.
module sf48_mix
  import seqmult_sched_sf_48_pkg::*;
#(
  parameter int N = DEF_N
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                en,
  input  logic signed [N-1:0] left,
  input  logic signed [N-1:0] right,
  output logic signed [N-1:0] lpr,
  output logic signed [N-1:0] lmr
);
  logic signed [N-1:0] lpr_q, lpr_d, lmr_q, lmr_d;

  always_comb begin
    lpr_d = lpr_q;
    lmr_d = lmr_q;
    if (en) begin
      lpr_d = (left + right) <<< MIX_SHIFT;
      lmr_d = (left - right) <<< MIX_SHIFT;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lpr_q <= '0;
      lmr_q <= '0;
    end else begin
      lpr_q <= lpr_d;
      lmr_q <= lmr_d;
    end
  end

  assign lpr = lpr_q;
  assign lmr = lmr_q;
endmodule

// File: rtl/seqmult_sched_sf_48.sv
// rtl/seqmult_sched_sf_48.sv - schedules L+R*Ks then L-R*Kd through one shared multiplier per 48 kHz strobe.
// Optional watchdog: MULT_TIMEOUT_EN.
module seqmult_sched_sf_48
  import seqmult_sched_sf_48_pkg::*;
#(
  parameter int N           = DEF_N,
  parameter int M           = DEF_M,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sample_en,
  input  logic signed [N-1:0]   LEFT,
  input  logic signed [N-1:0]   RIGHT,
  input  logic [3:0]            Ks,
  input  logic [3:0]            Kd,
  seqmult_sched_sf_48_if.master mif,
  output logic signed [N-1:0]   LI_in_LpR,
  output logic signed [N-1:0]   LI_in_LmR,
  output logic                  out_valid,
  output logic                  overrun,
  output logic                  timeout_err
);
  sched_state_e        state_q, state_d;
  logic [3:0]          ks_q, ks_d, kd_q, kd_d;
  logic signed [N-1:0] hold_s_q, hold_s_d, hold_d_q, hold_d_d;
  logic signed [N-1:0] lpr_out_q, lpr_out_d, lmr_out_q, lmr_out_d;
  logic                out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic                capture, use_d;
  logic signed [N-1:0] lpr, lmr, prod_scaled;

  sf48_mix #(.N(N)) u_mix (
    .clock (clock),
    .reset (reset),
    .en    (capture),
    .left  (LEFT),
    .right (RIGHT),
    .lpr   (lpr),
    .lmr   (lmr)
  );

  assign prod_scaled = mif.mult_R[OUT_SHIFT +: N];
  assign use_d = (state_q == ST_START_D) || (state_q == ST_BUSY_D) || (state_q == ST_DONE_D);

  // Operands come straight from held registers, so A/B stay stable for the whole multiply.
  assign mif.mult_A = use_d ? lmr : lpr;
  assign mif.mult_B = use_d ? M'({1'b0, kd_q}) : M'({1'b0, ks_q});

`ifdef MULT_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  logic [WD_W-1:0] wdog_q, wdog_d;
  logic            timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d        = state_q;
    ks_d           = ks_q;
    kd_d           = kd_q;
    hold_s_d       = hold_s_q;
    hold_d_d       = hold_d_q;
    lpr_out_d      = lpr_out_q;
    lmr_out_d      = lmr_out_q;
    out_valid_d    = 1'b0;
    overrun_d      = overrun_q;
    capture        = 1'b0;
    mif.mult_start = 1'b0;

    if (sample_en && state_q != ST_IDLE) overrun_d = 1'b1;

    unique case (state_q)
      ST_IDLE: if (sample_en) begin
        capture = 1'b1;
        ks_d    = Ks;
        kd_d    = Kd;
        state_d = ST_START_S;
      end
      ST_START_S: if (mif.mult_ready) begin
        mif.mult_start = 1'b1;
        state_d        = ST_BUSY_S;
      end
      ST_BUSY_S:  if (!mif.mult_ready) state_d = ST_DONE_S;
      ST_DONE_S: if (mif.mult_ready) begin
        hold_s_d = prod_scaled;
        state_d  = ST_START_D;
      end
      ST_START_D: if (mif.mult_ready) begin
        mif.mult_start = 1'b1;
        state_d        = ST_BUSY_D;
      end
      ST_BUSY_D:  if (!mif.mult_ready) state_d = ST_DONE_D;
      ST_DONE_D: if (mif.mult_ready) begin
        hold_d_d = prod_scaled;
        state_d  = ST_UPDATE;
      end
      ST_UPDATE: begin
        lpr_out_d   = hold_s_q;
        lmr_out_d   = hold_d_q;
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef MULT_TIMEOUT_EN
    wdog_d        = '0;
    timeout_err_d = timeout_err_q;
    if ((state_q == ST_BUSY_S || state_q == ST_DONE_S || state_q == ST_BUSY_D || state_q == ST_DONE_D)
        && !((state_q == ST_DONE_S || state_q == ST_DONE_D) && mif.mult_ready)) begin
      wdog_d = wdog_q + WD_W'(1);
      if (wdog_q >= WD_W'(TIMEOUT_CYC - 1)) begin
        state_d       = ST_IDLE;
        timeout_err_d = 1'b1;
        wdog_d        = '0;
      end
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      ks_q        <= '0;
      kd_q        <= '0;
      hold_s_q    <= '0;
      hold_d_q    <= '0;
      lpr_out_q   <= '0;
      lmr_out_q   <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ks_q        <= ks_d;
      kd_q        <= kd_d;
      hold_s_q    <= hold_s_d;
      hold_d_q    <= hold_d_d;
      lpr_out_q   <= lpr_out_d;
      lmr_out_q   <= lmr_out_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end

`ifdef MULT_TIMEOUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      wdog_q        <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      timeout_err_q <= timeout_err_d;
    end
  end
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  assign LI_in_LpR = lpr_out_q;
  assign LI_in_LmR = lmr_out_q;
  assign out_valid = out_valid_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_seqmult_sched_sf_48.sv
// tb/tb_seqmult_sched_sf_48.sv - scoreboard bench for seqmult_sched_sf_48 with the real seqmultNM.
module tb_seqmult_sched_sf_48;
  localparam int N  = 18;
  localparam int M  = 5;
  localparam int TO = 64;

  typedef struct { logic signed [N-1:0] a; logic [M-1:0] b; } start_t;
  typedef struct { logic signed [N-1:0] s; logic signed [N-1:0] d; } res_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic sample_en = 1'b0;
  logic signed [N-1:0] LEFT = '0, RIGHT = '0;
  logic [3:0] Ks = '0, Kd = '0;
  logic signed [N-1:0] LI_in_LpR, LI_in_LmR;
  logic out_valid, overrun, timeout_err;
  logic mul_ready;
  logic stall = 1'b0;

  int n_checks = 0, n_pass = 0, n_start = 0, n_valid = 0;
  start_t exp_start[$];
  res_t   exp_res[$];

  always #5 clock = ~clock;

  seqmult_sched_sf_48_if #(.N(N), .M(M)) sif ();

  seqmult_sched_sf_48 #(.N(N), .M(M), .TIMEOUT_CYC(TO)) dut (
    .clock(clock), .reset(reset), .sample_en(sample_en),
    .LEFT(LEFT), .RIGHT(RIGHT), .Ks(Ks), .Kd(Kd), .mif(sif),
    .LI_in_LpR(LI_in_LpR), .LI_in_LmR(LI_in_LmR),
    .out_valid(out_valid), .overrun(overrun), .timeout_err(timeout_err)
  );

  seqmultNM #(.N(N), .M(M)) u_mult (
    .clock(clock), .reset(reset), .start(sif.mult_start),
    .A(sif.mult_A), .B(sif.mult_B), .ready(mul_ready), .R(sif.mult_R)
  );

  assign sif.mult_ready = mul_ready & ~stall;

  task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic signed [N-1:0] mixv(input int l, input int r, input bit diff);
    logic signed [N-1:0] m;
    m = diff ? N'(l - r) : N'(l + r);
    return m <<< 3;
  endfunction

  function automatic logic signed [N-1:0] scaled(input logic signed [N-1:0] m, input int k);
    longint p;
    p = longint'(m) * longint'(k);
    return N'(p >>> 5);
  endfunction

  always @(negedge clock) begin
    if (!reset) begin
      if (sif.mult_start) begin
        n_start++;
        if (exp_start.size() == 0) chk("start_unexpected", 1, 0);
        else begin
          start_t e;
          e = exp_start.pop_front();
          chk("mult_A", sif.mult_A, e.a);
          chk("mult_B", $signed({1'b0, sif.mult_B}), $signed({1'b0, e.b}));
        end
      end
      if (out_valid) begin
        n_valid++;
        if (exp_res.size() == 0) chk("valid_unexpected", 1, 0);
        else begin
          res_t e;
          e = exp_res.pop_front();
          chk("LI_in_LpR", LI_in_LpR, e.s);
          chk("LI_in_LmR", LI_in_LmR, e.d);
        end
      end
    end
  end

  task automatic do_sample(input int l, input int r, input int ks, input int kd, input bit expect_ok);
    start_t s;
    res_t   e;
    @(posedge clock); #1;
    LEFT = N'(l); RIGHT = N'(r); Ks = 4'(ks); Kd = 4'(kd); sample_en = 1'b1;
    if (expect_ok) begin
      s.a = mixv(l, r, 1'b0); s.b = M'(ks); exp_start.push_back(s);
      s.a = mixv(l, r, 1'b1); s.b = M'(kd); exp_start.push_back(s);
      e.s = scaled(mixv(l, r, 1'b0), ks);
      e.d = scaled(mixv(l, r, 1'b1), kd);
      exp_res.push_back(e);
    end
    @(posedge clock); #1;
    sample_en = 1'b0;
  endtask

  task automatic wait_valid(input int target, input string tag);
    for (int i = 0; i < 60 && n_valid < target; i++) begin
      @(posedge clock); #2;
    end
    if (n_valid < target) chk(tag, n_valid, target);
  endtask

  task automatic wait_start(input int target);
    for (int i = 0; i < 60 && n_start < target; i++) begin
      @(posedge clock); #2;
    end
    if (n_start < target) chk("start_timeout", n_start, target);
  endtask

  initial begin
    int v0, s0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_lpr", LI_in_LpR, 0);
    chk("rst_lmr", LI_in_LmR, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout", timeout_err, 0);
    reset = 1'b0;

    // Test 1: basic scaling and two ordered multiplies
    v0 = n_valid; s0 = n_start;
    do_sample(100, 50, 8, 4, 1'b1);
    wait_valid(v0 + 1, "t1_valid_timeout");
    chk("t1_lpr_const", LI_in_LpR, 300);
    chk("t1_lmr_const", LI_in_LmR, 50);
    repeat (25) @(posedge clock);
    chk("t1_starts", n_start - s0, 2);
    chk("t1_valids", n_valid - v0, 1);

    // Test 2: negative mix, floor on division
    do_sample(-100, 0, 4, 1, 1'b1);
    wait_valid(v0 + 2, "t2_valid_timeout");
    chk("t2_lpr_const", LI_in_LpR, -100);
    chk("t2_lmr_const", LI_in_LmR, -25);

    // Test 3: overrun when a second strobe lands mid-operation
    v0 = n_valid;
    do_sample(1234, -567, 9, 13, 1'b1);
    @(posedge clock); #1;
    sample_en = 1'b1; LEFT = 18'sd7; RIGHT = 18'sd7;
    @(posedge clock); #1;
    sample_en = 1'b0;
    chk("t3_overrun", overrun, 1);
    wait_valid(v0 + 1, "t3_valid_timeout");
    repeat (25) @(posedge clock);
    chk("t3_valids", n_valid - v0, 1);
    chk("t3_overrun_sticky", overrun, 1);

    // Test 4: reset in BUSY_D abandons the sample
    s0 = n_start;
    do_sample(3000, 1000, 5, 7, 1'b1);
    wait_start(s0 + 2);
    reset = 1'b1;
    @(posedge clock); #1;
    exp_res.delete();
    exp_start.delete();
    chk("t4_lpr", LI_in_LpR, 0);
    chk("t4_lmr", LI_in_LmR, 0);
    chk("t4_overrun", overrun, 0);
    reset = 1'b0;
    v0 = n_valid;
    do_sample(-2000, 500, 15, 3, 1'b1);
    wait_valid(v0 + 1, "t4_valid_timeout");

    // Test 5: zero gain still produces out_valid
    v0 = n_valid;
    do_sample(1000, 1000, 0, 15, 1'b1);
    wait_valid(v0 + 1, "t5_valid_timeout");
    chk("t5_lpr_const", LI_in_LpR, 0);
    chk("t5_lmr_const", LI_in_LmR, 0);

    // Wrap-around boundary on the N-bit mix
    v0 = n_valid;
    do_sample(131071, 131071, 15, 15, 1'b1);
    wait_valid(v0 + 1, "wrap_valid_timeout");

`ifdef MULT_TIMEOUT_EN
    // Test 6: stuck ready triggers the watchdog
    begin
      logic signed [N-1:0] keep_s, keep_d;
      start_t s;
      keep_s = LI_in_LpR; keep_d = LI_in_LmR;
      v0 = n_valid; s0 = n_start;
      s.a = mixv(40, 20, 1'b0); s.b = M'(6); exp_start.push_back(s);
      @(posedge clock); #1;
      LEFT = 18'sd40; RIGHT = 18'sd20; Ks = 4'd6; Kd = 4'd2; sample_en = 1'b1;
      @(posedge clock); #1;
      sample_en = 1'b0;
      wait_start(s0 + 1);
      stall = 1'b1;
      for (int i = 0; i < TO + 20 && !timeout_err; i++) begin
        @(posedge clock); #2;
      end
      chk("t6_timeout_err", timeout_err, 1);
      stall = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      chk("t6_lpr_kept", LI_in_LpR, keep_s);
      chk("t6_lmr_kept", LI_in_LmR, keep_d);
      chk("t6_no_valid", n_valid - v0, 0);
    end
`endif

    repeat (5) @(posedge clock);
    chk("queue_res_empty", exp_res.size(), 0);
    chk("queue_start_empty", exp_start.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
